// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Drives ALU operands, function code and downstream destination/control.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [FUNC_W-1:0] id_func,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              hold,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] ALUA,
  output logic [DATA_W-1:0] ALUB,
  output logic [FUNC_W-1:0] Func,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_addr_q;
  logic [REG_AW-1:0] rt_addr_q;
  logic              alusrc_q;
  logic [DATA_W-1:0] fwd_a_data;
  logic [DATA_W-1:0] fwd_rt_data;

  // Forward source for one register address; r0 and bubbles never forward.
  function automatic logic [1:0] fwd_sel(
    input logic              valid,
    input logic [REG_AW-1:0] addr,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (valid && (addr != '0)) begin
      if (em_we && (em_rd == addr)) begin
        sel = FWD_EXMEM;
      end else if (mw_we && (mw_rd == addr)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(ex_valid, rs_addr_q, exmem_regwrite, exmem_rd,
                    memwb_regwrite, memwb_rd);
    fwd_b = fwd_sel(ex_valid, rt_addr_q, exmem_regwrite, exmem_rd,
                    memwb_regwrite, memwb_rd);

    fwd_a_data = rs_data_q;
    case (fwd_a)
      FWD_EXMEM: fwd_a_data = exmem_result;
      FWD_MEMWB: fwd_a_data = memwb_result;
      default:   fwd_a_data = rs_data_q;
    endcase

    fwd_rt_data = rt_data_q;
    case (fwd_b)
      FWD_EXMEM: fwd_rt_data = exmem_result;
      FWD_MEMWB: fwd_rt_data = memwb_result;
      default:   fwd_rt_data = rt_data_q;
    endcase

    ALUA          = fwd_a_data;
    ALUB          = alusrc_q ? imm_q : fwd_rt_data;
    ex_store_data = fwd_rt_data;
  end

  // Stage register: flush beats hold beats load; hold re-captures forwarded operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      Func        <= '0;
      ex_rd       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alusrc_q    <= 1'b0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      Func        <= '0;
      ex_rd       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alusrc_q    <= 1'b0;
    end else if (hold) begin
      rs_data_q   <= fwd_a_data;
      rt_data_q   <= fwd_rt_data;
    end else begin
      ex_valid    <= id_valid;
      ex_regwrite <= id_regwrite & id_valid;
      Func        <= id_func;
      ex_rd       <= id_rd_addr;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      alusrc_q    <= id_alusrc;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: load, forwarding priority, r0, hold, flush, async reset.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_func;
  logic        id_alusrc, id_regwrite, hold, flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [2:0]  exmem_rd, memwb_rd;
  logic [15:0] exmem_result, memwb_result;
  logic [15:0] ALUA, ALUB, ex_store_data;
  logic [2:0]  Func, ex_rd;
  logic        ex_valid, ex_regwrite;
  logic [1:0]  fwd_a, fwd_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_func(id_func), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .hold(hold), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ALUA(ALUA), .ALUB(ALUB), .Func(Func), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_store_data(ex_store_data),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic valid, input logic [2:0] rs, input logic [15:0] rsd,
                      input logic [2:0] rt, input logic [15:0] rtd, input logic [15:0] imm,
                      input logic [2:0] rd, input logic [2:0] fn, input logic src);
    id_valid = valid; id_rs_addr = rs; id_rs_data = rsd;
    id_rt_addr = rt; id_rt_data = rtd; id_imm = imm;
    id_rd_addr = rd; id_func = fn; id_alusrc = src; id_regwrite = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    load(1'b0, 3'd0, 16'h0, 3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0);
    exmem_regwrite = 1'b0; exmem_rd = 3'd0; exmem_result = 16'h0;
    memwb_regwrite = 1'b0; memwb_rd = 3'd0; memwb_result = 16'h0;
    #12;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_alua",  32'(ALUA), 32'd0);
    check("rst_alub",  32'(ALUB), 32'd0);
    check("rst_func",  32'(Func), 32'd0);
    check("rst_fwd",   32'({fwd_a, fwd_b}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Plain load, no forwarding.
    load(1'b1, 3'd1, 16'd5, 3'd2, 16'd7, 16'h0, 3'd4, 3'b000, 1'b0);
    tick();
    check("s1_alua",  32'(ALUA), 32'd5);
    check("s1_alub",  32'(ALUB), 32'd7);
    check("s1_func",  32'(Func), 32'd0);
    check("s1_valid", 32'(ex_valid), 32'd1);
    check("s1_fwd",   32'({fwd_a, fwd_b}), 32'd0);
    check("s1_rd",    32'(ex_rd), 32'd4);
    check("s1_rw",    32'(ex_regwrite), 32'd1);

    // EX/MEM over MEM/WB, then MEM/WB alone.
    load(1'b1, 3'd3, 16'h0011, 3'd2, 16'd7, 16'h0, 3'd4, 3'b010, 1'b0);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 3'd3; exmem_result = 16'h1234;
    memwb_regwrite = 1'b1; memwb_rd = 3'd3; memwb_result = 16'h5678;
    #1;
    check("s2_alua_em", 32'(ALUA), 32'h1234);
    check("s2_fwda_em", 32'(fwd_a), 32'd2);
    check("s2_func",    32'(Func), 32'd2);
    exmem_rd = 3'd5; #1;
    check("s2_alua_mw", 32'(ALUA), 32'h5678);
    check("s2_fwda_mw", 32'(fwd_a), 32'd1);

    // r0 never forwarded.
    load(1'b1, 3'd0, 16'h0, 3'd2, 16'd7, 16'h0, 3'd4, 3'b000, 1'b0);
    exmem_rd = 3'd0; exmem_result = 16'hFFFF; memwb_rd = 3'd0;
    tick();
    check("s3_alua_r0", 32'(ALUA), 32'd0);
    check("s3_fwda_r0", 32'(fwd_a), 32'd0);

    // Immediate on ALUB while rt still forwarded to store data.
    load(1'b1, 3'd1, 16'h0022, 3'd6, 16'h0101, 16'h000F, 3'd4, 3'b001, 1'b1);
    exmem_rd = 3'd6; exmem_result = 16'hAAAA; memwb_regwrite = 1'b0;
    tick();
    check("s4_alub",  32'(ALUB), 32'h000F);
    check("s4_store", 32'(ex_store_data), 32'hAAAA);
    check("s4_fwdb",  32'(fwd_b), 32'd2);
    check("s4_alua",  32'(ALUA), 32'h0022);

    // rt from MEM/WB on ALUB.
    load(1'b1, 3'd1, 16'h0022, 3'd2, 16'h0101, 16'h000F, 3'd4, 3'b001, 1'b0);
    exmem_rd = 3'd6; memwb_regwrite = 1'b1; memwb_rd = 3'd2; memwb_result = 16'h4242;
    tick();
    check("s4b_alub", 32'(ALUB), 32'h4242);
    check("s4b_fwdb", 32'(fwd_b), 32'd1);

    // Bubble in EX never forwards.
    load(1'b0, 3'd3, 16'h0033, 3'd2, 16'h0101, 16'h0, 3'd4, 3'b001, 1'b0);
    exmem_rd = 3'd3; exmem_result = 16'h1234; memwb_regwrite = 1'b0;
    tick();
    check("s4c_alua", 32'(ALUA), 32'h0033);
    check("s4c_fwda", 32'(fwd_a), 32'd0);
    check("s4c_rw",   32'(ex_regwrite), 32'd0);

    // Hold keeps the forwarded operand after the producer leaves.
    load(1'b1, 3'd3, 16'h0001, 3'd2, 16'd7, 16'h0, 3'd4, 3'b101, 1'b0);
    tick();
    check("s5_alua_pre", 32'(ALUA), 32'h1234);
    hold = 1'b1;
    load(1'b1, 3'd1, 16'hBEEF, 3'd1, 16'hBEEF, 16'h0, 3'd7, 3'b111, 1'b0);
    tick();
    exmem_result = 16'h9999; exmem_rd = 3'd5; #1;
    check("s5_alua_hold", 32'(ALUA), 32'h1234);
    check("s5_fwda_hold", 32'(fwd_a), 32'd0);
    check("s5_valid",     32'(ex_valid), 32'd1);
    check("s5_func",      32'(Func), 32'b101);
    tick();
    check("s5_alua_hold2", 32'(ALUA), 32'h1234);
    flush = 1'b1;
    tick();
    check("s5_fl_valid", 32'(ex_valid), 32'd0);
    check("s5_fl_rw",    32'(ex_regwrite), 32'd0);
    check("s5_fl_func",  32'(Func), 32'd0);
    check("s5_fl_alua",  32'(ALUA), 32'd0);
    hold = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-cycle, then a clean reload.
    exmem_regwrite = 1'b0;
    load(1'b1, 3'd1, 16'd5, 3'd2, 16'd7, 16'h0, 3'd4, 3'b011, 1'b0);
    tick();
    check("s6_valid_pre", 32'(ex_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_valid", 32'(ex_valid), 32'd0);
    check("s6_rst_alua",  32'(ALUA), 32'd0);
    check("s6_rst_func",  32'(Func), 32'd0);
    check("s6_rst_rw",    32'(ex_regwrite), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    load(1'b1, 3'd1, 16'd5, 3'd2, 16'd7, 16'h0, 3'd4, 3'b000, 1'b0);
    tick();
    check("s6_alua", 32'(ALUA), 32'd5);
    check("s6_alub", 32'(ALUB), 32'd7);
    check("s6_valid", 32'(ex_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
